// File: rtl/halfword_serializer_pkg.sv
// Shared definitions for the half-word serializer: op encodings, FSM states, default width.
// Op codes share encoding with the extender op field so one decode drives both blocks.
package halfword_serializer_pkg;

    localparam int HALF_W_DEF = 16;

    localparam logic [1:0] NARROW_LO   = 2'b00;
    localparam logic [1:0] NARROW_LO_S = 2'b01;
    localparam logic [1:0] NARROW_HI   = 2'b10;
    localparam logic [1:0] NARROW_WORD = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_FIRST = 2'd1;
    localparam state_t ST_LAST  = 2'd2;

endpackage

// File: rtl/halfword_serializer.sv
// Narrows 2*HALF_W words to HALF_W beats; first beat one cycle after accept.
// Stalled beats hold all outputs; input is only accepted when the final beat leaves.
module halfword_serializer
    import halfword_serializer_pkg::*;
#(
    parameter int HALF_W = HALF_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*HALF_W-1:0] in_data,
    input  logic [1:0]          in_ops,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [HALF_W-1:0]   out_data,
    output logic                out_last,
    output logic                out_ovf
);

    state_t              state;
    logic [HALF_W-1:0]   hold;
    logic [HALF_W-1:0]   lo_half;
    logic [HALF_W-1:0]   hi_half;
    logic                accept;

    assign lo_half   = in_data[HALF_W-1:0];
    assign hi_half   = in_data[2*HALF_W-1:HALF_W];
    assign out_valid = (state != ST_IDLE);

    // out_ready -> in_ready is the only combinational path through the block
    assign in_ready = !rst && ((state == ST_IDLE) || ((state == ST_LAST) && out_ready));
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            out_data <= '0;
            out_last <= 1'b0;
            out_ovf  <= 1'b0;
            hold     <= '0;
        end else if (accept) begin
            case (in_ops)
                NARROW_WORD: begin
                    state    <= ST_FIRST;
                    out_data <= lo_half;
                    hold     <= hi_half;
                    out_last <= 1'b0;
                    out_ovf  <= 1'b0;
                end
                NARROW_LO_S: begin
                    state    <= ST_LAST;
                    out_data <= lo_half;
                    out_last <= 1'b1;
                    // overflow when the high half is not a sign extension of the low half
                    out_ovf  <= (hi_half != {HALF_W{lo_half[HALF_W-1]}});
                end
                NARROW_HI: begin
                    state    <= ST_LAST;
                    out_data <= hi_half;
                    out_last <= 1'b1;
                    out_ovf  <= 1'b0;
                end
                default: begin
                    state    <= ST_LAST;
                    out_data <= lo_half;
                    out_last <= 1'b1;
                    out_ovf  <= 1'b0;
                end
            endcase
        end else if ((state == ST_FIRST) && out_ready) begin
            state    <= ST_LAST;
            out_data <= hold;
            out_last <= 1'b1;
            out_ovf  <= 1'b0;
        end else if ((state == ST_LAST) && out_ready) begin
            state <= ST_IDLE;
        end
    end

endmodule

// File: tb/tb_halfword_serializer.sv
// Self-checking bench for halfword_serializer: directed scenarios plus a randomized run
// scored against a queue-of-beats reference model.
module tb_halfword_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [1:0]  in_ops = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_ovf;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic        ovf;
    } beat_t;

    beat_t model_q[$];

    halfword_serializer #(.HALF_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ops    (in_ops),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    // Outputs are sampled 1ns after the rising edge, well away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: the list of beats a word produces, straight from the op table.
    task automatic model_push(input logic [31:0] w, input logic [1:0] op);
        beat_t b;
        int    hi_signed;
        hi_signed = $signed(w);
        case (op)
            2'b00: begin b.data = w[15:0]; b.last = 1'b1; b.ovf = 1'b0; model_q.push_back(b); end
            2'b01: begin
                b.data = w[15:0];
                b.last = 1'b1;
                b.ovf  = (hi_signed < -32768) || (hi_signed > 32767);
                model_q.push_back(b);
            end
            2'b10: begin b.data = w[31:16]; b.last = 1'b1; b.ovf = 1'b0; model_q.push_back(b); end
            default: begin
                b.data = w[15:0];  b.last = 1'b0; b.ovf = 1'b0; model_q.push_back(b);
                b.data = w[31:16]; b.last = 1'b1; b.ovf = 1'b0; model_q.push_back(b);
            end
        endcase
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++;
        if ({out_valid, out_last, out_ovf, out_data, in_ready} !== 20'h0) begin
            failures++;
            $display("FAIL reset_outputs got v=%b l=%b o=%b d=%h r=%b want all 0",
                     out_valid, out_last, out_ovf, out_data, in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_single(input logic [31:0] w, input logic [1:0] op,
                               input logic [15:0] exp_d, input logic exp_ovf);
        in_valid = 1'b1; in_data = w; in_ops = op; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_last, out_ovf, out_data} !== {1'b1, 1'b1, exp_ovf, exp_d}) begin
            failures++;
            $display("FAIL single_op%0d_beat got v=%b l=%b o=%b d=%h want v=1 l=1 o=%b d=%h",
                     op, out_valid, out_last, out_ovf, out_data, exp_ovf, exp_d);
        end
        tick();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL single_op%0d_idle got v=%b r=%b want v=0 r=1", op, out_valid, in_ready);
        end
    endtask

    task automatic test_word_stall();
        in_valid = 1'b1; in_data = 32'hCAFE_F00D; in_ops = 2'b11; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({out_valid, out_last, out_ovf, out_data, in_ready} !== {3'b100, 16'hF00D, 1'b0}) begin
                failures++;
                $display("FAIL word_stall_first[%0d] got v=%b l=%b o=%b d=%h r=%b want v=1 l=0 o=0 d=f00d r=0",
                         i, out_valid, out_last, out_ovf, out_data, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL word_first_ready got %b want 0", in_ready);
        end
        tick();
        checks++;
        if ({out_valid, out_last, out_ovf, out_data} !== {3'b110, 16'hCAFE}) begin
            failures++;
            $display("FAIL word_second got v=%b l=%b o=%b d=%h want v=1 l=1 o=0 d=cafe",
                     out_valid, out_last, out_ovf, out_data);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL word_done_idle got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w = $urandom;
            in_valid = 1'b1; in_data = w; in_ops = 2'b00;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready[%0d] got %b want 1", i, in_ready);
            end
            tick();
            checks++;
            if ({out_valid, out_last, out_data} !== {2'b11, w[15:0]}) begin
                failures++;
                $display("FAIL b2b_beat[%0d] got v=%b l=%b d=%h want v=1 l=1 d=%h",
                         i, out_valid, out_last, out_data, w[15:0]);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_word();
        in_valid = 1'b1; in_data = 32'hAAAA_5555; in_ops = 2'b11; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_last, out_ovf, out_data, in_ready} !== 20'h0) begin
            failures++;
            $display("FAIL midword_reset got v=%b l=%b o=%b d=%h r=%b want all 0",
                     out_valid, out_last, out_ovf, out_data, in_ready);
        end
        tick();
        rst = 1'b0;
        in_valid = 1'b1; in_data = 32'h1357_2468; in_ops = 2'b10; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_last, out_ovf, out_data} !== {3'b110, 16'h1357}) begin
            failures++;
            $display("FAIL midword_after got v=%b l=%b o=%b d=%h want v=1 l=1 o=0 d=1357",
                     out_valid, out_last, out_ovf, out_data);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midword_no_stale got v=%b d=%h want v=0", out_valid, out_data);
        end
    endtask

    task automatic test_random();
        logic        xfer;
        logic        acc;
        logic        exp_rdy;
        logic [15:0] lo;
        beat_t       b;
        int          words_left;
        int          budget;
        model_q.delete();
        words_left = 300;
        budget = 5000;
        while ((words_left > 0 || model_q.size() != 0) && budget > 0) begin
            budget--;
            checks++;
            if (model_q.size() == 0) begin
                if (out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL rand_valid got 1 want 0");
                end
            end else begin
                b = model_q[0];
                if ({out_valid, out_data, out_last, out_ovf} !== {1'b1, b}) begin
                    failures++;
                    $display("FAIL rand_beat got v=%b d=%h l=%b o=%b want v=1 d=%h l=%b o=%b",
                             out_valid, out_data, out_last, out_ovf, b.data, b.last, b.ovf);
                end
            end
            if (!in_valid && words_left > 0 && ($urandom_range(3) != 0)) begin
                lo = 16'($urandom);
                in_ops = 2'($urandom);
                if ($urandom_range(1) == 1)
                    in_data = {{16{lo[15]}}, lo};
                else
                    in_data = {16'($urandom), lo};
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(3) != 0);
            #1;
            exp_rdy = (model_q.size() == 0) || (model_q.size() == 1 && out_ready);
            checks++;
            if (in_ready !== exp_rdy) begin
                failures++;
                $display("FAIL rand_in_ready got %b want %b", in_ready, exp_rdy);
            end
            xfer = out_valid && out_ready;
            acc  = in_valid && in_ready;
            tick();
            if (xfer && model_q.size() != 0) void'(model_q.pop_front());
            if (acc) begin
                model_push(in_data, in_ops);
                in_valid = 1'b0;
                words_left--;
            end
        end
        checks++;
        if (budget == 0) begin
            failures++;
            $display("FAIL rand_timeout words_left=%0d pending=%0d want 0 0", words_left, model_q.size());
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single(32'h1234_ABCD, 2'b00, 16'hABCD, 1'b0);
        test_single(32'hFFFF_8000, 2'b01, 16'h8000, 1'b0);
        test_single(32'h0001_7FFF, 2'b01, 16'h7FFF, 1'b1);
        test_single(32'hDEAD_BEEF, 2'b10, 16'hDEAD, 1'b0);
        test_word_stall();
        test_back_to_back();
        test_reset_mid_word();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
